serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: captures operands on start, resolves one bit per
// cycle LSB first, and publishes sum/cout/overflow with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_s;
    logic               w_c_next;
    logic               w_last;
    logic               w_capture;
    logic [WIDTH-1:0]   w_res_next;

    // Subtraction is a + ~b + 1: invert b per bit, seed the carry with 1.
    assign w_a_bit   = r_a[r_cnt];
    assign w_b_bit   = r_b[r_cnt] ^ r_sub;
    assign w_s       = w_a_bit ^ w_b_bit ^ r_carry;
    assign w_c_next  = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_capture = start && ((r_state == IDLE) || (r_state == DONE));

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res_bit
            assign w_res_next[gi] = (r_cnt == CNT_W'(gi)) ? w_s : r_res[gi];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = ADD;
            ADD:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? ADD : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_a     <= a;
                r_b     <= b;
                r_sub   <= sub;
                r_carry <= sub ? 1'b1 : cin;
                r_cnt   <= '0;
                r_res   <= '0;
            end else if (r_state == ADD) begin
                r_carry <= w_c_next;
                r_res   <= w_res_next;
                if (!w_last) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    r_sum  <= w_res_next;
                    r_cout <= w_c_next;
                    r_ovf  <= r_carry ^ w_c_next;
                end
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign busy     = (r_state == ADD);
    assign done     = (r_state == DONE);

endmodule
